// File: rtl/sd_rw_emu_pkg.sv
// Shared types for the SD read/write controller emulator: FSM encoding,
// the out-of-range read fill word and a small constant helper.
package sd_rw_emu_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_LAT,
        ST_WR_DATA,
        ST_WR_TAIL,
        ST_RD_LAT,
        ST_RD_DATA
    } sd_rw_state_e;

    localparam logic [15:0] SD_OOR_FILL = 16'hFFFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sd_rw_emu_if.sv
// Bus between an SD data generator (master) and the SD controller or its
// emulator (slave), with a debug view of the slave FSM state.
interface sd_rw_emu_if;
    // Handshake: a start pulse is taken only while the slave is idle, and the
    // matching busy flag rises on the next clock. wr_req is a one-clock pull
    // for the next write word (the master registers it on that edge).
    // rd_val_en qualifies rd_val_data in the same cycle. No backpressure.
    logic                          sd_init_done;
    logic                          wr_start_en;
    logic [31:0]                   wr_sec_addr;
    logic [15:0]                   wr_data;
    logic                          wr_busy;
    logic                          wr_req;
    logic                          rd_start_en;
    logic [31:0]                   rd_sec_addr;
    logic                          rd_busy;
    logic                          rd_val_en;
    logic [15:0]                   rd_val_data;
    sd_rw_emu_pkg::sd_rw_state_e   dbg_state;

    modport master (
        output wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
        input  sd_init_done, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        input  dbg_state
    );

    modport slave (
        input  wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
        output sd_init_done, wr_busy, wr_req, rd_busy, rd_val_en, rd_val_data,
        output dbg_state
    );
endinterface

// File: rtl/sd_emu_ram.sv
// Simple dual-port sector store: one write port, one read port, registered
// read data (1-clock latency). Contents are never reset.
module sd_emu_ram #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_rw_emu.sv
// SD read/write controller emulator backed by on-chip RAM.
// Build option SD_RW_EMU_ERR_INJ_EN flips bit 0 of read word ERR_WORD.
module sd_rw_emu
    import sd_rw_emu_pkg::*;
#(
    parameter int          SEC_WORDS = 256,
    parameter int          NUM_SECS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'd2000000,
    parameter int          INIT_DLY  = 32,
    parameter int          CMD_LAT   = 8,
    parameter int          WORD_GAP  = 1,
    parameter int          WR_TAIL   = 16
`ifdef SD_RW_EMU_ERR_INJ_EN
    ,
    parameter int          ERR_WORD  = 5
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    sd_rw_emu_if.slave bus
);

    localparam int WW = $clog2(SEC_WORDS);
    localparam int CW = WW + 1;
    localparam int IW = $clog2(NUM_SECS);
    localparam int AW = IW + WW;
    localparam int LW = $clog2(max3(INIT_DLY, CMD_LAT, WR_TAIL) + 1);
    localparam int GW = (WORD_GAP > 0) ? $clog2(WORD_GAP + 1) : 1;

    sd_rw_state_e  state;
    logic [LW-1:0] lat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] samp_cnt;
    logic [IW-1:0] sec_idx;
    logic          in_range;
    logic          init_done_r;
    logic          wr_busy_r;
    logic          wr_req_r;
    logic          wr_req_q;
    logic          rd_busy_r;
    logic          rd_val_en_r;
    logic [15:0]   rd_val_data_r;

    logic [31:0]   wr_off;
    logic [31:0]   rd_off;
    logic          rd_fire;
    logic [WW-1:0] rd_word;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [15:0]   ram_rdata;
    logic [15:0]   rd_word_data;

    assign wr_off = bus.wr_sec_addr - BASE_ADDR;
    assign rd_off = bus.rd_sec_addr - BASE_ADDR;

    // Prefetch: on a cycle that emits word k, already address word k+1 so
    // back-to-back strobes see fresh RAM data despite the read latency.
    assign rd_fire = ((state == ST_RD_LAT) && (lat_cnt == LW'(CMD_LAT - 1))) ||
                     ((state == ST_RD_DATA) && (gap_cnt == '0) &&
                      (word_cnt != CW'(SEC_WORDS)));
    assign rd_word = rd_fire ? (word_cnt[WW-1:0] + WW'(1)) : word_cnt[WW-1:0];

    // wr_req_q marks the clock on which the producer's registered word is valid.
    assign ram_we    = (state == ST_WR_DATA) && wr_req_q && in_range;
    assign ram_waddr = {sec_idx, samp_cnt[WW-1:0]};
    assign ram_raddr = {sec_idx, rd_word};

`ifdef SD_RW_EMU_ERR_INJ_EN
    assign rd_word_data = (in_range ? ram_rdata : SD_OOR_FILL) ^
                          {15'd0, (word_cnt == CW'(ERR_WORD))};
`else
    assign rd_word_data = in_range ? ram_rdata : SD_OOR_FILL;
`endif

    sd_emu_ram #(
        .DW (16),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.wr_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            lat_cnt       <= '0;
            gap_cnt       <= '0;
            word_cnt      <= '0;
            samp_cnt      <= '0;
            sec_idx       <= '0;
            in_range      <= 1'b0;
            init_done_r   <= 1'b0;
            wr_busy_r     <= 1'b0;
            wr_req_r      <= 1'b0;
            wr_req_q      <= 1'b0;
            rd_busy_r     <= 1'b0;
            rd_val_en_r   <= 1'b0;
            rd_val_data_r <= 16'h0000;
        end else begin
            wr_req_r    <= 1'b0;
            rd_val_en_r <= 1'b0;
            wr_req_q    <= wr_req_r;
            case (state)
                ST_INIT: begin
                    if (lat_cnt == LW'(INIT_DLY - 1)) begin
                        lat_cnt     <= '0;
                        init_done_r <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_IDLE: begin
                    lat_cnt  <= '0;
                    gap_cnt  <= '0;
                    word_cnt <= '0;
                    samp_cnt <= '0;
                    // Write wins when both starts arrive together.
                    if (bus.wr_start_en) begin
                        sec_idx   <= wr_off[IW-1:0];
                        in_range  <= (wr_off < 32'(NUM_SECS));
                        wr_busy_r <= 1'b1;
                        state     <= ST_WR_LAT;
                    end else if (bus.rd_start_en) begin
                        sec_idx   <= rd_off[IW-1:0];
                        in_range  <= (rd_off < 32'(NUM_SECS));
                        rd_busy_r <= 1'b1;
                        state     <= ST_RD_LAT;
                    end
                end
                ST_WR_LAT: begin
                    if (lat_cnt == LW'(CMD_LAT - 1)) begin
                        lat_cnt  <= '0;
                        wr_req_r <= 1'b1;
                        word_cnt <= CW'(1);
                        gap_cnt  <= GW'(WORD_GAP);
                        state    <= ST_WR_DATA;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_WR_DATA: begin
                    if (word_cnt != CW'(SEC_WORDS)) begin
                        if (gap_cnt == '0) begin
                            wr_req_r <= 1'b1;
                            word_cnt <= word_cnt + CW'(1);
                            gap_cnt  <= GW'(WORD_GAP);
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                    if (wr_req_q) begin
                        samp_cnt <= samp_cnt + CW'(1);
                        if (samp_cnt == CW'(SEC_WORDS - 1)) begin
                            state <= ST_WR_TAIL;
                        end
                    end
                end
                ST_WR_TAIL: begin
                    if (lat_cnt == LW'(WR_TAIL - 1)) begin
                        lat_cnt   <= '0;
                        wr_busy_r <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_RD_LAT: begin
                    if (lat_cnt == LW'(CMD_LAT - 1)) begin
                        lat_cnt       <= '0;
                        rd_val_en_r   <= 1'b1;
                        rd_val_data_r <= rd_word_data;
                        word_cnt      <= CW'(1);
                        gap_cnt       <= GW'(WORD_GAP);
                        state         <= ST_RD_DATA;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_RD_DATA: begin
                    if (word_cnt == CW'(SEC_WORDS)) begin
                        rd_busy_r <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (gap_cnt == '0) begin
                        rd_val_en_r   <= 1'b1;
                        rd_val_data_r <= rd_word_data;
                        word_cnt      <= word_cnt + CW'(1);
                        gap_cnt       <= GW'(WORD_GAP);
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.sd_init_done = init_done_r;
    assign bus.wr_busy      = wr_busy_r;
    assign bus.wr_req       = wr_req_r;
    assign bus.rd_busy      = rd_busy_r;
    assign bus.rd_val_en    = rd_val_en_r;
    assign bus.rd_val_data  = rd_val_data_r;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_sd_rw_emu.sv
// Bench for sd_rw_emu: init timing, table of sector writes/reads against a
// sector model, out-of-range and collision cases, and reset during a read.
module tb_sd_rw_emu;
    import sd_rw_emu_pkg::*;

    localparam logic [31:0] BASE = 32'd2000000;
    localparam int          SW   = 256;

    typedef struct {
        logic        wr_en;
        logic        rd_en;
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;
        int          wr_mode;
        logic        exp_wr;
        logic        exp_rd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_mode = 0;
    int   wr_k = 0;

    logic [15:0] exp_q[$];
    logic [31:0] rd_t_q[$];
    logic [31:0] wr_t_q[$];
    logic [15:0] model_mem [4][SW];
    vec_t        vecs [12];

    sd_rw_emu_if bus ();

    sd_rw_emu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] data_of(input int mode, input int i);
        case (mode)
            0:       return 16'd5;
            1:       return 16'(i);
            2:       return 16'hA000 | 16'(i);
            default: return 16'hC000 ^ 16'(i * 3);
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input logic [31:0] idx, input int i);
        logic [15:0] w;
        w = (idx < 32'd4) ? model_mem[idx[1:0]][i] : 16'hFFFF;
`ifdef SD_RW_EMU_ERR_INJ_EN
        if (i == 5) w = w ^ 16'h0001;
`endif
        return w;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Mimics a generator that registers its next word on each wr_req edge.
    task automatic producer();
        forever begin
            @(negedge clk);
            if (bus.wr_req) begin
                @(posedge clk);
                #1;
                bus.wr_data = data_of(wr_mode, wr_k);
                wr_k++;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.wr_req) begin
                if (wr_t_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_req_unexpected: pulse at cycle %0d", cyc);
                end else begin
                    check("wr_req_time", cyc, wr_t_q.pop_front());
                end
            end
            if (bus.rd_val_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_val_unexpected: strobe at cycle %0d data %0h", cyc, bus.rd_val_data);
                end else begin
                    check("rd_val_time", cyc, rd_t_q.pop_front());
                    check("rd_val_data", bus.rd_val_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_init_done"}, bus.sd_init_done, 0);
        check({tag, "_wr_busy"}, bus.wr_busy, 0);
        check({tag, "_wr_req"}, bus.wr_req, 0);
        check({tag, "_rd_busy"}, bus.rd_busy, 0);
        check({tag, "_rd_val_en"}, bus.rd_val_en, 0);
        check({tag, "_rd_val_data"}, bus.rd_val_data, 16'h0000);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_INIT));
    endtask

    // Called at the negedge on which reset is released; start at k==10 must be ignored.
    task automatic init_sequence();
        for (int k = 1; k <= 34; k++) begin
            bus.wr_start_en = (k == 10);
            bus.wr_sec_addr = BASE;
            @(posedge clk);
            @(negedge clk);
            check("init_done", bus.sd_init_done, (k >= 32) ? 1 : 0);
            check("init_no_wr_busy", bus.wr_busy, 0);
        end
        bus.wr_start_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          t0;
        logic [31:0] widx;
        logic [31:0] ridx;
        logic [15:0] first_word;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.wr_start_en = v.wr_en;
        bus.rd_start_en = v.rd_en;
        bus.wr_sec_addr = v.wr_addr;
        bus.rd_sec_addr = v.rd_addr;
        wr_mode = v.wr_mode;
        wr_k = 0;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        bus.wr_start_en = 1'b0;
        bus.rd_start_en = 1'b0;
        check("wr_busy_rise", bus.wr_busy, v.exp_wr);
        check("rd_busy_rise", bus.rd_busy, v.exp_rd);
        first_word = 16'h0;
        if (v.exp_wr) begin
            widx = v.wr_addr - BASE;
            for (int i = 0; i < SW; i++) begin
                wr_t_q.push_back(32'(t0 + 8 + 2 * i));
                if (widx < 32'd4) model_mem[widx[1:0]][i] = data_of(v.wr_mode, i);
            end
        end
        if (v.exp_rd) begin
            ridx = v.rd_addr - BASE;
            first_word = exp_word(ridx, 0);
            for (int i = 0; i < SW; i++) begin
                rd_t_q.push_back(32'(t0 + 8 + 2 * i));
                exp_q.push_back(exp_word(ridx, i));
            end
        end
        if (v.exp_wr) begin
            wait_cyc(t0 + 535);
            check("wr_busy_tail", bus.wr_busy, 1);
            wait_cyc(t0 + 536);
            check("wr_busy_fall", bus.wr_busy, 0);
        end else if (v.exp_rd) begin
            wait_cyc(t0 + 9);
            check("rd_data_hold", bus.rd_val_data, first_word);
            wait_cyc(t0 + 518);
            check("rd_busy_last", bus.rd_busy, 1);
            wait_cyc(t0 + 519);
            check("rd_busy_fall", bus.rd_busy, 0);
        end else begin
            wait_cyc(t0 + 540);
        end
        check("rd_busy_idle", bus.rd_busy, 0);
        check("wr_q_drained", 32'(wr_t_q.size()), 0);
        check("rd_q_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic reset_mid_read();
        int t0;
        @(negedge clk);
        bus.rd_start_en = 1'b1;
        bus.rd_sec_addr = BASE;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        bus.rd_start_en = 1'b0;
        for (int i = 0; i < SW; i++) begin
            rd_t_q.push_back(32'(t0 + 8 + 2 * i));
            exp_q.push_back(exp_word(0, i));
        end
        wait_cyc(t0 + 8 + 200);
        check("mid_read_strobe", bus.rd_val_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rd_t_q.delete();
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset_hold");
        rst_n = 1'b1;
        init_sequence();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_start_en = 1'b0;
        bus.rd_start_en = 1'b0;
        bus.wr_sec_addr = 32'd0;
        bus.rd_sec_addr = 32'd0;
        bus.wr_data = 16'h0000;

        fork
            producer();
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog: cycle %0d", cyc);
                $fatal(1, "watchdog expired");
            end
        join_none

        //          wr    rd    wr_addr       rd_addr       mode exp_wr exp_rd
        vecs[0]  = '{1'b1, 1'b0, BASE,         32'd0,        0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'd0,        BASE,         0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, BASE + 1,     32'd0,        1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd0,        BASE,         0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'd0,        BASE + 1,     0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'd0,        BASE - 1,     0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'd0,        BASE + 4,     0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, BASE + 3,     BASE,         3, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'd0,        BASE + 3,     0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, BASE + 4,     32'd0,        2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'd0,        BASE,         0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'd0,        BASE + 1,     0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        init_sequence();

        for (int n = 0; n < 12; n++) begin
            run_vec(vecs[n]);
        end

        reset_mid_read();
        run_vec(vecs[10]);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
